// File: rtl/lsu_rmw.sv
// Load/store unit: byte/half/word access to a word-only data memory, sub-word stores via read-modify-write.
// Optional misalignment trapping is built when LSU_MISALIGN_TRAP_EN is defined.
module lsu_rmw #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_SB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SW  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

`ifdef LSU_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {IDLE, ACCESS, WRITE, RESP, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, ACCESS, WRITE, RESP} state_t;
`endif

  state_t              state, nxt;
  logic [2:0]          op_p0;
  logic [1:0]          off_p0;
  logic [31:0]         wdata_p0;
  logic [ADDR_W-1:0]   maddr_p0;
  logic [31:0]         merge_p1;
  logic [31:0]         rdata_p2;
  logic                accept, op_sw, op_sub_store, op_load;

  // Big-endian lane pick followed by sign or zero extension.
  function automatic logic [31:0] extract(input logic [2:0] op, input logic [31:0] w,
                                          input logic [1:0] off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (op)
      OP_LB:   extract = 32'(b);
      OP_LBU:  extract = {24'd0, b};
      OP_LH:   extract = 32'(h);
      OP_LHU:  extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [2:0] op, input logic [31:0] w,
                                        input logic [15:0] d, input logic [1:0] off);
    merge = w;
    if (op == OP_SH) begin
      if (off[1]) merge[15:0] = d;
      else        merge[31:16] = d;
    end else begin
      case (off)
        2'd0:    merge[31:24] = d[7:0];
        2'd1:    merge[23:16] = d[7:0];
        2'd2:    merge[15:8]  = d[7:0];
        default: merge[7:0]   = d[7:0];
      endcase
    end
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: misaligned = a[0];
      OP_LW, OP_SW:         misaligned = |a;
      default:              misaligned = 1'b0;
    endcase
  endfunction
`endif

  assign accept       = (state == IDLE) && req_valid;
  assign op_sw        = (op_p0 == OP_SW);
  assign op_sub_store = (op_p0 == OP_SB) || (op_p0 == OP_SH);
  assign op_load      = !op_sw && !op_sub_store;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
          nxt = misaligned(req_op, req_addr[1:0]) ? ERR : ACCESS;
`else
          nxt = ACCESS;
`endif
        end
      end
      ACCESS:  nxt = op_sub_store ? WRITE : RESP;
      WRITE:   nxt = RESP;
`ifdef LSU_MISALIGN_TRAP_EN
      ERR:     nxt = RESP;
`endif
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // A write in flight is dropped combinationally when reset lands on it.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_we     = 1'b0;
    mem_wd     = 32'd0;
    case (state)
      ACCESS: begin
        if (op_sw) begin
          mem_we = !reset;
          mem_wd = wdata_p0;
        end
      end
      WRITE: begin
        mem_we = !reset;
        mem_wd = merge(op_p0, merge_p1, wdata_p0[15:0], off_p0);
      end
      default: ;
    endcase
  end

  // Stage p0: latched request; p1: read word for merge.
  always_ff @(posedge clock) begin
    if (accept) begin
      op_p0    <= req_op;
      off_p0   <= req_addr[1:0];
      wdata_p0 <= req_wdata;
    end
    if (state == ACCESS && op_sub_store) merge_p1 <= mem_rd;
  end

  // Stage p2: response registers, loaded only when entering RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      maddr_p0 <= '0;
      rdata_p2 <= '0;
    end else begin
      if (state == IDLE && nxt == ACCESS) maddr_p0 <= {req_addr[ADDR_W-1:2], 2'b00};
      if (nxt == RESP)
        rdata_p2 <= (state == ACCESS && op_load) ? extract(op_p0, mem_rd, off_p0) : 32'd0;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_p2;
  always_ff @(posedge clock) begin
    if (reset)            err_p2 <= 1'b0;
    else if (nxt == RESP) err_p2 <= (state == ERR);
  end
  assign resp_err = err_p2;
`else
  assign resp_err = 1'b0;
`endif

  assign mem_addr   = maddr_p0;
  assign resp_rdata = rdata_p2;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw: byte-array memory model plus literal expectations from the test plan.
module tb_lsu_rmw;
  localparam int ADDR_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;

  lsu_rmw #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clock = ~clock;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, SB = 3'b011;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101, SW = 3'b110, SH = 3'b111;

  // Word memory seen by the DUT, with a preload port used only while idle.
  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx;
  logic [31:0] pl_word;
  assign mem_rd = mem[mem_addr[7:2]];
  always @(posedge clock) begin
    if (mem_we)     mem[mem_addr[7:2]] <= mem_wd;
    else if (pl_en) mem[pl_idx] <= pl_word;
  end

  // Reference model: memory as big-endian bytes.
  logic [7:0] mdl [0:255];

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  bit          pend = 0, pend_abort = 0, p_err;
  logic [31:0] p_rdata, p_wd, p_waddr;
  int          p_lat, p_we, acc_cyc, we_seen, resp_count = 0;
  logic [31:0] last_rdata, last_wd;
  logic        last_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mword(input logic [31:0] a);
    mword = {mdl[a[7:0]], mdl[a[7:0] + 8'd1], mdl[a[7:0] + 8'd2], mdl[a[7:0] + 8'd3]};
  endfunction

  task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    int          size;
    bit          st, sgn;
    logic [31:0] ea, v;
    logic [7:0]  bi;
    size = (op == LB || op == SB || op == LBU) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
    st   = (op == SB || op == SW || op == SH);
    sgn  = (op == LB || op == LH);
    ea   = addr - (addr % 32'(size));
`ifdef LSU_MISALIGN_TRAP_EN
    p_err = (ea != addr);
`else
    p_err = 1'b0;
`endif
    p_rdata = 32'd0; p_we = 0; p_lat = 2; p_wd = 32'd0; p_waddr = 32'd0;
    if (!p_err && st) begin
      for (int i = 0; i < size; i++) begin
        bi = ea[7:0] + 8'(i);
        mdl[bi] = 8'(wd >> (8 * (size - 1 - i)));
      end
      p_we    = 1;
      p_lat   = (size == 4) ? 2 : 3;
      p_waddr = ea & ~32'h3;
      p_wd    = mword(p_waddr);
    end else if (!p_err) begin
      v = 32'd0;
      for (int i = 0; i < size; i++) begin
        bi = ea[7:0] + 8'(i);
        v  = (v << 8) | {24'd0, mdl[bi]};
      end
      if (sgn && v[8 * size - 1]) v = v | (32'hFFFFFFFF << (8 * size));
      p_rdata = v;
    end
  endtask

  // Compare process: every memory write and every response against the model.
  always @(negedge clock) begin
    if (pend && req_valid && req_ready) acc_cyc = cyc;
    if (mem_we === 1'b1) begin
      last_wd = mem_wd;
      if (pend && !pend_abort && p_we != 0) begin
        check("write data", mem_wd, p_wd);
        check("write addr", mem_addr, p_waddr);
        we_seen++;
      end else check("unexpected mem_we", {31'd0, mem_we}, 32'd0);
    end
    if (resp_valid === 1'b1) begin
      if (pend && !pend_abort) begin
        check("latency", 32'(cyc - acc_cyc), 32'(p_lat));
        check("resp_rdata", resp_rdata, p_rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, p_err});
        check("write count", 32'(we_seen), 32'(p_we));
        last_rdata = resp_rdata;
        last_err   = resp_err;
        pend = 0;
        resp_count++;
      end else check("unexpected resp_valid", {31'd0, resp_valid}, 32'd0);
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    pl_idx = a[7:2]; pl_word = w; pl_en = 1'b1;
    for (int i = 0; i < 4; i++) mdl[a[7:0] + 8'(i)] = 8'(w >> (24 - 8 * i));
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input bit abort);
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (req_ready !== 1'b1) check("req_ready timeout", {31'd0, req_ready}, 32'd1);
    if (!abort) model(op, addr, wd);
    else begin
      p_we = 0; p_err = 0; p_rdata = 0; p_lat = 0;
    end
    we_seen = 0; pend_abort = abort; pend = 1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_op = SW;
  endtask

  task automatic wait_resp();
    int start = resp_count;
    int n = 0;
    while (resp_count == start && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    if (resp_count == start) begin
      checks++; errors++;
      $display("FAIL response timeout: got none, expected resp_valid");
      pend = 0;
    end
  endtask

  task automatic op_lit(input string name, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp);
    issue(op, addr, wd, 0);
    wait_resp();
    check(name, last_rdata, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = LB; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset outputs", {resp_err, mem_we, 30'd0}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wd", mem_wd, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);

    preload(32'h10, 32'h8899AABB);
    issue(LW, 32'h10, 32'd0, 0);
    check("LW mem_addr in ACCESS", mem_addr, 32'h10);
    wait_resp();
    check("LW 0x10", last_rdata, 32'h8899AABB);
    check("LW 0x10 err", {31'd0, last_err}, 32'd0);

    preload(32'h20, 32'h12F45678);
    op_lit("LB 0x21", LB, 32'h21, 0, 32'hFFFFFFF4);
    op_lit("LBU 0x21", LBU, 32'h21, 0, 32'h000000F4);
    op_lit("LH 0x22", LH, 32'h22, 0, 32'h00005678);
    op_lit("LHU 0x20", LHU, 32'h20, 0, 32'h000012F4);
    op_lit("LB 0x23", LB, 32'h23, 0, 32'h00000078);
    op_lit("LH 0x20", LH, 32'h20, 0, 32'h000012F4);

    preload(32'h30, 32'h11223344);
    issue(SB, 32'h33, 32'h000000AB, 0);
    wait_resp();
    check("SB 0x33 mem_wd", last_wd, 32'h112233AB);

    preload(32'h40, 32'hCAFE0001);
    issue(SH, 32'h40, 32'h0000BEEF, 0);
    wait_resp();
    check("SH 0x40 mem_wd", last_wd, 32'hBEEF0001);
    op_lit("LW 0x40 after SH", LW, 32'h40, 0, 32'hBEEF0001);

    preload(32'h50, 32'hA1B2C3D4);
    issue(SB, 32'h50, 32'hFFFFFF11, 0); wait_resp();
    issue(SB, 32'h51, 32'h00000022, 0); wait_resp();
    issue(SB, 32'h52, 32'h00000033, 0); wait_resp();
    issue(SH, 32'h52, 32'hFFFF7777, 0); wait_resp();
    op_lit("LW 0x50 after merges", LW, 32'h50, 0, 32'h11227777);
    issue(SW, 32'h54, 32'h01020304, 0); wait_resp();
    op_lit("LH 0x56", LH, 32'h56, 0, 32'h00000304);
    op_lit("LB 0x54", LB, 32'h54, 0, 32'h00000001);

    issue(SW, 32'h42, 32'hDEADBEEF, 0);
    wait_resp();
`ifdef LSU_MISALIGN_TRAP_EN
    check("SW 0x42 err", {31'd0, last_err}, 32'd1);
    check("SW 0x42 rdata", last_rdata, 32'd0);
    op_lit("LW 0x40 after bad SW", LW, 32'h40, 0, 32'hBEEF0001);
    op_lit("LH 0x41 misaligned", LH, 32'h41, 0, 32'd0);
    check("LH 0x41 err", {31'd0, last_err}, 32'd1);
    op_lit("LW 0x20 after err", LW, 32'h20, 0, 32'h12F45678);
    check("err cleared", {31'd0, last_err}, 32'd0);
`else
    check("SW 0x42 mem_wd", last_wd, 32'hDEADBEEF);
    op_lit("LW 0x40 after SW 0x42", LW, 32'h40, 0, 32'hDEADBEEF);
    op_lit("LH 0x41 ignores bit0", LH, 32'h41, 0, 32'hFFFFDEAD);
    op_lit("LW 0x43 ignores low bits", LW, 32'h43, 0, 32'hDEADBEEF);
`endif

    // Reset during the WRITE cycle of an SB aborts it.
    issue(SB, 32'h30, 32'h00000055, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("abort mem_we in WRITE", {31'd0, mem_we}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort req_ready", {31'd0, req_ready}, 32'd1);
    check("abort resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort mem_we", {31'd0, mem_we}, 32'd0);
    check("abort mem_addr", mem_addr, 32'd0);
    check("abort mem_wd", mem_wd, 32'd0);
    check("abort resp_rdata", resp_rdata, 32'd0);
    check("abort resp_err", {31'd0, resp_err}, 32'd0);
    repeat (4) @(posedge clock);
    #1;
    pend = 0; pend_abort = 0;
    op_lit("LW 0x30 after abort", LW, 32'h30, 0, 32'h112233AB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store unit between the MIPS datapath and the word-wide data memory. It accepts one byte, halfword or word request at a time from the core and drives the memory's word port. It extracts and extends sub-word load data. Sub-word stores are done as a read-modify-write sequence, because the data memory writes whole 32-bit words only.

## Interface
Parameters:
- `ADDR_W`, default 32: width of the request and memory addresses.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: core presents a request.
- `req_ready`  out  1: unit is idle and can accept a request; 1 only in IDLE.
- `req_op`  in  3: operation code, one of:
  - 000 LB
  - 001 LH
  - 010 LW
  - 011 SB
  - 100 LBU
  - 101 LHU
  - 110 SW
  - 111 SH
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1: one-cycle pulse marking completion of the accepted request.
- `resp_rdata`  out  32: load result, extended; 0 for stores and errors.
- `resp_err`  out  1: misaligned access, valid with `resp_valid`.
- `mem_addr`  out  ADDR_W: word-port address; memory uses [ADDR_W-1:2].
- `mem_we`  out  1: memory write enable.
- `mem_wd`  out  32: memory write data.
- `mem_rd`  in  32: memory read data, combinational from `mem_addr`.

## Operation
- Handshake:
  - A request is accepted on a rising edge where `req_valid & req_ready` is true.
  - At acceptance, op, address and wdata are latched.
  - Inputs are ignored while busy.
  - There is no response backpressure.
- Byte order is big-endian:
  - Byte offset 0 is lane [31:24] and offset 3 is [7:0].
  - Half offset 0 is [31:16] and offset 2 is [15:0].
- Load extension:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through unchanged.
- States:
  - IDLE: `req_ready`=1; `mem_addr` holds its last value. On accept, go to ERR if misaligned, otherwise to ACCESS.
  - ACCESS: `mem_addr` = latched address with [1:0] cleared.
    - Loads: capture the extracted value; go to RESP.
    - SW: `mem_we`=1 and `mem_wd`=wdata; go to RESP.
    - SB/SH: capture `mem_rd` into the merge register; go to WRITE.
  - WRITE: `mem_we`=1; `mem_wd` = merge register with the addressed lane replaced by the low byte or half of wdata; go to RESP.
  - ERR: no memory access (`mem_we`=0); go to RESP with `resp_err`=1.
  - RESP: `resp_valid`=1 for exactly one cycle; go to IDLE.
- Misalignment:
  - LH, LHU and SH are misaligned when addr[0]=1.
  - LW and SW are misaligned when addr[1:0]≠0.
  - Byte operations are never misaligned.
- `mem_we` is asserted only in ACCESS (SW) or WRITE, for exactly one cycle per store.

## Timing
- Reset values, applied on the rising edge with `reset`=1:
  - state=IDLE, `req_ready`=1
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0
  - `mem_we`=0, `mem_addr`=0, `mem_wd`=0
- Reset mid-operation aborts the request. No write occurs at or after the reset edge, and no response is issued.
- Latency, counted in cycles from the acceptance edge to the `resp_valid` cycle:
  - Loads and SW: 2 (IDLE → ACCESS → RESP).
  - SB/SH: 3 (through WRITE).
  - Misaligned: 2.
- Throughput: one request per 3 cycles (loads/SW) or 4 cycles (SB/SH); `req_ready` returns to 1 in the cycle after RESP.
- `resp_rdata` and `resp_err` are registered. They are held stable from the RESP cycle until the next response.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misalignment is checked as described above.
  - Misaligned requests take the ERR path and report `resp_err`=1.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - No checking; the ERR state is not built.
  - Halfword operations ignore addr[0]; word operations ignore addr[1:0].
  - `resp_err` is tied to 0.

## Test plan
- Reset, then LW with `mem_rd`=0x8899AABB at addr 0x10:
  - `mem_addr`=0x10 in ACCESS.
  - `resp_valid` 2 cycles after accept with `resp_rdata`=0x8899AABB, `resp_err`=0.
- Loads from memory word 0x12F45678 at base 0x20:
  - LB at 0x21 → 0xFFFFFFF4.
  - LBU at 0x21 → 0x000000F4.
  - LH at 0x22 → 0x00005678.
  - LHU at 0x20 → 0x000012F4.
- SB wdata 0x000000AB at 0x33 over stored 0x11223344:
  - Exactly one `mem_we` pulse, in WRITE, with `mem_wd`=0x112233AB.
  - `resp_valid` 3 cycles after accept.
- SH wdata 0x0000BEEF at 0x40 over 0xCAFE0001:
  - `mem_wd`=0xBEEF0001.
  - A following LW at 0x40 returns 0xBEEF0001.
- With `LSU_MISALIGN_TRAP_EN`:
  - SW at 0x42 → `mem_we` never asserted; `resp_err`=1 and `resp_rdata`=0, 2 cycles after accept.
  - Without the macro, the same SW writes word 0x40.
- Assert `reset` in the WRITE cycle of an SB:
  - No `mem_we` at that edge or after; no `resp_valid`.
  - `req_ready`=1 on the next cycle and all outputs at their reset values.
